// File: rtl/alu4_pkg.sv
`default_nettype none
// =============================================================================
// alu4_pkg : shared select encodings, compare bit indices and datapath width
// Rev 1.0
// =============================================================================
package alu4_pkg;

  localparam int W = 4;

  typedef enum logic [1:0] {
    SEL_ADD = 2'b00,
    SEL_SUB = 2'b01,
    SEL_CMP = 2'b10,
    SEL_AND = 2'b11
  } sel_e;

  localparam int CMP_GT = 2;
  localparam int CMP_EQ = 1;
  localparam int CMP_LT = 0;

endpackage
`default_nettype wire

// File: rtl/alu4_main_circuit_if.sv
`default_nettype none
// =============================================================================
// alu4_main_circuit_if : operand/select inputs and registered result buses
// Rev 1.0
// =============================================================================
interface alu4_main_circuit_if;
  import alu4_pkg::*;

  logic [1:0]   s;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W:0]   adder;
  logic [W:0]   subs;
  logic [2:0]   comp;
  logic [W-1:0] and_op;
  logic [3:0]   d;

  modport master (output s, a, b, input adder, subs, comp, and_op, d);
  modport slave  (input s, a, b, output adder, subs, comp, and_op, d);
endinterface
`default_nettype wire

// File: rtl/alu4_full_adder.sv
`default_nettype none
// =============================================================================
// alu4_full_adder : 1-bit full adder, ripple cell for the add and subtract chains
// Rev 1.0
// =============================================================================
module alu4_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule
`default_nettype wire

// File: rtl/alu4_main_circuit.sv
`default_nettype none
// =============================================================================
// alu4_main_circuit : registered 4-bit ALU (add/sub/compare/AND), one-hot gated
// Rev 1.0
// =============================================================================
module alu4_main_circuit
  import alu4_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  alu4_main_circuit_if.slave bus
);
  logic [3:0]   w_dec;
  logic [W:0]   w_add_c;
  logic [W:0]   w_sub_c;
  logic [W-1:0] w_add_s;
  logic [W-1:0] w_sub_s;
  logic [W-1:0] w_b_inv;
  logic         w_borrow;
  logic         w_eq;
  logic [2:0]   w_comp;

  logic [W:0]   r_adder;
  logic [W:0]   r_subs;
  logic [2:0]   r_comp;
  logic [W-1:0] r_and;
  logic [3:0]   r_d;

  assign w_dec      = 4'b0001 << bus.s;
  assign w_add_c[0] = 1'b0;
  // Subtract as A + ~B + 1; the final carry is the inverted borrow
  assign w_sub_c[0] = 1'b1;
  assign w_b_inv    = ~bus.b;

  generate
    for (genvar i = 0; i < W; i++) begin : g_ripple
      alu4_full_adder u_add (
        .a    (bus.a[i]),
        .b    (bus.b[i]),
        .cin  (w_add_c[i]),
        .sum  (w_add_s[i]),
        .cout (w_add_c[i+1])
      );
      alu4_full_adder u_sub (
        .a    (bus.a[i]),
        .b    (w_b_inv[i]),
        .cin  (w_sub_c[i]),
        .sum  (w_sub_s[i]),
        .cout (w_sub_c[i+1])
      );
    end
  endgenerate

  assign w_borrow       = ~w_sub_c[W];
  assign w_eq           = (w_sub_s == '0);
  assign w_comp[CMP_LT] = w_borrow;
  assign w_comp[CMP_EQ] = w_eq;
  assign w_comp[CMP_GT] = ~w_borrow & ~w_eq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_adder <= '0;
      r_subs  <= '0;
      r_comp  <= '0;
      r_and   <= '0;
      r_d     <= '0;
    end else begin
      r_d     <= w_dec;
      r_adder <= w_dec[SEL_ADD] ? {w_add_c[W], w_add_s} : '0;
      r_subs  <= w_dec[SEL_SUB] ? {w_borrow, w_sub_s}   : '0;
      r_comp  <= w_dec[SEL_CMP] ? w_comp                : '0;
      r_and   <= w_dec[SEL_AND] ? (bus.a & bus.b)       : '0;
    end
  end

  assign bus.adder  = r_adder;
  assign bus.subs   = r_subs;
  assign bus.comp   = r_comp;
  assign bus.and_op = r_and;
  assign bus.d      = r_d;
endmodule
`default_nettype wire

// File: tb/tb_alu4_main_circuit.sv
`default_nettype none
// =============================================================================
// tb_alu4_main_circuit : directed vectors, expected results queued and checked by a monitor
// Rev 1.0
// =============================================================================
module tb_alu4_main_circuit;

  typedef struct packed {
    logic [4:0] adder;
    logic [4:0] subs;
    logic [2:0] comp;
    logic [3:0] and_op;
    logic [3:0] d;
  } res_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  res_t  exp_q[$];
  string name_q[$];

  alu4_main_circuit_if bus ();

  alu4_main_circuit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t mk(input logic [4:0] ad, input logic [4:0] su,
                              input logic [2:0] co, input logic [3:0] an,
                              input logic [3:0] dd);
    mk = {ad, su, co, an, dd};
  endfunction

  function automatic res_t got_now();
    got_now = {bus.adder, bus.subs, bus.comp, bus.and_op, bus.d};
  endfunction

  task automatic check(input string name, input res_t got, input res_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got adder=%b subs=%b comp=%b and_op=%b d=%b, required adder=%b subs=%b comp=%b and_op=%b d=%b",
               name, got.adder, got.subs, got.comp, got.and_op, got.d,
               exp.adder, exp.subs, exp.comp, exp.and_op, exp.d);
    end
  endtask

  // Called at a negedge: drive inputs, queue the result due after the next posedge
  task automatic apply(input string name, input logic [1:0] s, input logic [3:0] a,
                       input logic [3:0] b, input res_t exp);
    bus.s = s;
    bus.a = a;
    bus.b = b;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(negedge clk);
  endtask

  // Monitor: every active edge out of reset with a pending expectation
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        check(name_q.pop_front(), got_now(), exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.s = 2'b00;
    bus.a = 4'b0000;
    bus.b = 4'b0000;
    #2;
    check("reset_state", got_now(), '0);
    repeat (2) @(negedge clk);
    check("reset_held", got_now(), '0);

    rst_n = 1'b1;
    apply("first_edge_add", 2'b00, 4'b0101, 4'b1100, mk(5'b10001, 5'b0, 3'b0, 4'b0, 4'b0001));

    // Asynchronous clear between edges, then hold across an edge
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", got_now(), '0);
    @(posedge clk);
    #1;
    check("reset_mid_hold", got_now(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    apply("release_add", 2'b00, 4'b0101, 4'b1100, mk(5'b10001, 5'b0, 3'b0, 4'b0, 4'b0001));

    apply("add_6_1",   2'b00, 4'b0110, 4'b0001, mk(5'b00111, 5'b0, 3'b0, 4'b0, 4'b0001));
    apply("add_15_15", 2'b00, 4'b1111, 4'b1111, mk(5'b11110, 5'b0, 3'b0, 4'b0, 4'b0001));
    apply("add_0_0",   2'b00, 4'b0000, 4'b0000, mk(5'b00000, 5'b0, 3'b0, 4'b0, 4'b0001));

    apply("sub_7_1",   2'b01, 4'b0111, 4'b0001, mk(5'b0, 5'b00110, 3'b0, 4'b0, 4'b0010));
    apply("sub_8_8",   2'b01, 4'b1000, 4'b1000, mk(5'b0, 5'b00000, 3'b0, 4'b0, 4'b0010));
    apply("sub_1_8",   2'b01, 4'b0001, 4'b1000, mk(5'b0, 5'b11001, 3'b0, 4'b0, 4'b0010));

    apply("cmp_gt",    2'b10, 4'b0001, 4'b0000, mk(5'b0, 5'b0, 3'b100, 4'b0, 4'b0100));
    apply("cmp_lt",    2'b10, 4'b0011, 4'b1001, mk(5'b0, 5'b0, 3'b001, 4'b0, 4'b0100));
    apply("cmp_eq",    2'b10, 4'b1000, 4'b1000, mk(5'b0, 5'b0, 3'b010, 4'b0, 4'b0100));

    apply("and_zero",  2'b11, 4'b0010, 4'b0001, mk(5'b0, 5'b0, 3'b0, 4'b0000, 4'b1000));
    apply("and_same",  2'b11, 4'b1101, 4'b1101, mk(5'b0, 5'b0, 3'b0, 4'b1101, 4'b1000));

    apply("seq_add",   2'b00, 4'b1010, 4'b0110, mk(5'b10000, 5'b0, 3'b0, 4'b0, 4'b0001));
    apply("seq_sub",   2'b01, 4'b1010, 4'b0110, mk(5'b0, 5'b00100, 3'b0, 4'b0, 4'b0010));
    apply("seq_cmp",   2'b10, 4'b1010, 4'b0110, mk(5'b0, 5'b0, 3'b100, 4'b0, 4'b0100));
    apply("seq_and",   2'b11, 4'b1010, 4'b0110, mk(5'b0, 5'b0, 3'b0, 4'b0010, 4'b1000));
    apply("seq_add2",  2'b00, 4'b1010, 4'b0110, mk(5'b10000, 5'b0, 3'b0, 4'b0, 4'b0001));

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending results, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
